data_memory_be: RTL and testbench
=================================

DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter DEPTH, default 256, number of words (power of two, 2..4096).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width; ADDR_W >= log2(DEPTH)+log2(DATA_W/8).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port mem_read, input, 1, read request, sampled on a clk edge.
REQ-008 SHALL have port mem_write, input, 1, write request, sampled on a clk edge.
REQ-009 SHALL have port addr, input, ADDR_W, byte address.
REQ-010 SHALL have port write_data, input, DATA_W, write word.
REQ-011 SHALL have port byte_en, input, DATA_W/8, per-byte write enable; bit i selects write_data[8i+7:8i].
REQ-012 SHALL have port read_data, output, DATA_W, registered read word.
REQ-013 SHALL have port read_valid, output, 1, one-cycle pulse, high when read_data is updated.
REQ-014 SHALL have port ready, output, 1, high when requests are accepted.
REQ-015 SHALL have port addr_err, output, 1, one-cycle pulse on a rejected request.

Function
REQ-016 SHALL implement FSM states INIT and RUN; rst_n low forces INIT and resets the clear index to 0.
REQ-017 In INIT, SHALL write zero to word[index] each cycle, increment index, hold ready=0, and ignore all requests.
REQ-018 SHALL go INIT->RUN after the cycle that clears word DEPTH-1, i.e. ready rises exactly DEPTH cycles after reset release.
REQ-019 In RUN, SHALL hold ready=1 and accept a request on every cycle where mem_read or mem_write is 1.
REQ-020 SHALL compute word index = addr[log2(DEPTH)+log2(B)-1 : log2(B)], with B = DATA_W/8.
REQ-021 SHALL reject a request if addr[log2(B)-1:0] != 0 (misaligned) or any addr bit above the index field is 1 (out of range).
REQ-022 On rejection, SHALL pulse addr_err for one cycle, leave memory unchanged, and not pulse read_valid.
REQ-023 On an accepted write, SHALL update only the byte lanes with byte_en=1 at the clock edge; byte_en=0 everywhere is a legal no-op.
REQ-024 On an accepted read, SHALL load read_data at that edge and drive read_valid=1 for the following cycle (latency 1).
REQ-025 On simultaneous read and write to the same word, SHALL return the merged post-write word (write-first).
REQ-026 SHALL hold read_data at its last value when no read is accepted; read_valid=0 in those cycles.
REQ-027 Back-to-back reads SHALL each produce one read_valid pulse, so read_valid stays high continuously.
REQ-028 A write at cycle N followed by a read of the same word at cycle N+1 SHALL return the written data.

Reset
REQ-029 rst_n low SHALL asynchronously drive read_data=0, read_valid=0, ready=0, addr_err=0, state=INIT, index=0.
REQ-030 Memory contents SHALL NOT be cleared by rst_n itself; they are zeroed only by the INIT sequence.
REQ-031 rst_n asserted mid-INIT or mid-RUN SHALL abort any in-flight request and restart the clear from index 0 on release.

Verification
REQ-032 Reset release with defaults -> ready=0 for 256 cycles, then 1; reading addr 0x3FC then returns 0 with read_valid.
REQ-033 Write 0xF0000001 at addr 0x0 with byte_en=4'b1111, then write 0x0000AB00 with byte_en=4'b0010, then read 0x0 -> read_data 0xF000AB01, read_valid pulses one cycle after the read.
REQ-034 Read at 0x2 (misaligned) or 0x400 (out of range) -> addr_err pulses one cycle; read_valid stays 0; read_data is unchanged.
REQ-035 Read and write together at 0x8, data 0x0F000003, byte_en=4'b1111 -> read_data=0x0F000003 on the next cycle.
REQ-036 Request issued during INIT -> ignored: no write, no read_valid, no addr_err.
REQ-037 rst_n pulsed low at cycle 100 of INIT -> all outputs 0 at once; ready rises 256 cycles after the new release.

Source files
------------

// File: rtl/data_memory_be.sv
// Byte-enabled single-port data memory. After reset it zeroes itself one word per cycle,
// then serves aligned, in-range requests with a one-cycle registered read.
module data_memory_be #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    output logic                ready,
    output logic                addr_err
);

    localparam int unsigned B     = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = $clog2(B);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(B - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             state;
    logic [IDX_W-1:0]   clr_idx;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [IDX_W-1:0]   word_idx;
    logic               misaligned;
    logic               out_of_range;
    logic               req;
    logic               bad;
    logic               wr_acc;
    logic               rd_acc;
    logic               init_we;
    logic [DATA_W-1:0]  merged;

    assign word_idx     = IDX_W'(addr >> OFF_W);
    assign misaligned   = |(addr & OFF_MASK);
    assign out_of_range = |(addr >> (IDX_W + OFF_W));
    assign bad          = misaligned | out_of_range;
    assign req          = (state == StRun) && (mem_read || mem_write);
    assign wr_acc       = req && mem_write && !bad;
    assign rd_acc       = req && mem_read && !bad;
    // Gate on rst_n so a held reset never touches memory contents.
    assign init_we      = rst_n && (state == StInit);

    // Write-first view of the addressed word for same-cycle read/write.
    always_comb begin
        merged = mem[word_idx];
        for (int i = 0; i < int'(B); i++) begin
            if (wr_acc && byte_en[i]) begin
                merged[8*i +: 8] = write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < int'(B); i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StInit;
            clr_idx    <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            ready      <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            read_valid <= 1'b0;
            addr_err   <= 1'b0;
            unique case (state)
                StInit: begin
                    clr_idx <= clr_idx + IDX_W'(1);
                    if (clr_idx == IDX_W'(DEPTH - 1)) begin
                        state <= StRun;
                        ready <= 1'b1;
                    end
                end
                StRun: begin
                    ready <= 1'b1;
                    if (req && bad) begin
                        addr_err <= 1'b1;
                    end
                    if (rd_acc) begin
                        read_data  <= merged;
                        read_valid <= 1'b1;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_be.sv
// Randomized bench for data_memory_be against a word-array reference model.
module tb_data_memory_be;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic [31:0] read_data;
    logic        read_valid;
    logic        ready;
    logic        addr_err;

    data_memory_be #(
        .DATA_W (32),
        .DEPTH  (256),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .byte_en    (byte_en),
        .read_data  (read_data),
        .read_valid (read_valid),
        .ready      (ready),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_mem [256];
    logic        model_ready;
    logic [31:0] exp_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = '0;
        write_data = '0;
        byte_en    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"}, read_data, 0);
        check({tag, "_rv"}, read_valid, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_err"}, addr_err, 0);
    endtask

    // Counts edges from release until ready; optionally re-pulses reset after abort_at edges.
    task automatic run_init(input int abort_at);
        int n;
        int abort;
        n = 0;
        abort = abort_at;
        model_ready = 1'b0;
        while (n < 2000) begin
            if (n == 10) begin
                mem_read = 1'b1; mem_write = 1'b1; addr = 32'h8;
                write_data = 32'hDEADBEEF; byte_en = 4'hF;
            end else begin
                idle_inputs();
            end
            @(posedge clk);
            #1;
            n++;
            if (abort != 0 && n == abort) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                #2;
                rst_n = 1'b1;
                n = 0;
                abort = 0;
            end else begin
                check("init_rv", read_valid, 0);
                check("init_err", addr_err, 0);
                if (ready) break;
            end
        end
        idle_inputs();
        check("init_len", n, 256);
        check("init_rdata", read_data, 0);
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        exp_rd = '0;
        model_ready = 1'b1;
    endtask

    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        logic exp_rv;
        logic exp_err;
        int   w;
        mem_read = rd; mem_write = wr; addr = a; write_data = wd; byte_en = be;
        @(posedge clk);
        #1;
        exp_rv = 1'b0;
        exp_err = 1'b0;
        if (model_ready && (rd || wr)) begin
            if ((a % 4) != 0 || a >= 32'h400) begin
                exp_err = 1'b1;
            end else begin
                w = int'(a / 4);
                if (wr) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) model_mem[w][8*i +: 8] = wd[8*i +: 8];
                end
                if (rd) begin
                    exp_rd = model_mem[w];
                    exp_rv = 1'b1;
                end
            end
        end
        check("rv", read_valid, exp_rv);
        check("err", addr_err, exp_err);
        check("rdata", read_data, exp_rd);
        check("ready", ready, model_ready);
        idle_inputs();
    endtask

    task automatic rand_cycles(input int count);
        logic [31:0] a;
        int          r;
        for (int k = 0; k < count; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 255)) * 4;
            else if (r == 8) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            else             a = $urandom | 32'h400;
            do_cycle(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
        end
    endtask

    initial begin
        idle_inputs();
        model_ready = 1'b0;
        exp_rd = '0;
        rst_n = 1'b0;
        #12;
        check_reset_outputs("por");
        rst_n = 1'b1;
        run_init(0);

        // Cleared word at the top of memory, and the request made during INIT left no trace.
        do_cycle(1'b1, 1'b0, 32'h3FC, 32'h0, 4'h0);
        check("top_word", read_data, 32'h0);
        do_cycle(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        check("init_req_ignored", read_data, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        do_cycle(1'b0, 1'b1, 32'h0, 32'hF0000001, 4'b1111);
        do_cycle(1'b0, 1'b1, 32'h0, 32'h0000AB00, 4'b0010);
        do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("merge_bytes", read_data, 32'hF000AB01);
        check("merge_rv", read_valid, 1);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("rv_drop", read_valid, 0);

        do_cycle(1'b1, 1'b0, 32'h2, 32'h0, 4'h0);
        check("misalign_err", addr_err, 1);
        do_cycle(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        check("range_err", addr_err, 1);
        check("range_hold", read_data, 32'hF000AB01);
        do_cycle(1'b0, 1'b1, 32'h402, 32'h12345678, 4'hF);

        do_cycle(1'b1, 1'b1, 32'h8, 32'h0F000003, 4'b1111);
        check("write_first", read_data, 32'h0F000003);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        do_cycle(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'b0000);
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("be_none_noop", read_data, 32'h0);

        rand_cycles(500);

        // Reset during RUN with a request pending, then a second pulse mid-INIT.
        mem_read = 1'b1; mem_write = 1'b1; addr = 32'h0; write_data = 32'h55AA55AA; byte_en = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("run_rst");
        #2;
        rst_n = 1'b1;
        run_init(100);
        do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("cleared_after_rst", read_data, 32'h0);
        rand_cycles(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
